traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised two-road intersection controller: the next generation of the single-road RGY sequencer. It drives North-South and East-West signal heads, each with the one-hot 3-bit encoding RED=3'b100, GREEN=3'b010 and YELLOW=3'b001. Each phase has a programmable duration, and an all-red clearance interval separates the two roads. A latched pedestrian request inserts a WALK phase with all heads red. An enable input freezes the sequence for manual hold, and a phase code is exported for debug and monitoring.

## Interface
Parameters:
- CNT_W, 8: phase timer width. Every duration must satisfy 1 <= T <= 2^CNT_W.
- GREEN_T, 10: green duration in enabled cycles, same for both roads.
- YELLOW_T, 3: yellow duration in enabled cycles.
- ALLRED_T, 2: all-red clearance duration in enabled cycles.
- WALK_T, 6: pedestrian walk duration in enabled cycles.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  advance enable. While low, the timer and state hold.
- ped_req  input  1  pedestrian request. Level or pulse; sampled every edge.
- light_ns  output  3  North-South head, one-hot.
- light_ew  output  3  East-West head, one-hot.
- walk  output  1  pedestrian walk indication.
- phase  output  3  current state code.

## Operation
State codes:
- 0 NS_G: light_ns GREEN, light_ew RED.
- 1 NS_Y: light_ns YELLOW, light_ew RED.
- 2 RED_A: both heads RED; clearance after NS.
- 3 EW_G: light_ew GREEN, light_ns RED.
- 4 EW_Y: light_ew YELLOW, light_ns RED.
- 5 RED_B: both heads RED; clearance after EW.
- 6 WALK: both heads RED, walk=1.

Outputs:
- All outputs are a pure decode of the registered state (Moore). No output depends combinationally on an input.
- walk=1 only in WALK. light_ns and light_ew are never GREEN or YELLOW at the same time.

Phase timer:
- On entry to any state, the timer loads T-1 for that state.
- On each edge with en=1: if timer≠0 it decrements; if timer=0 the state transitions.
- Each state therefore lasts exactly T enabled cycles.
- With en=0, state and timer hold. Disabled cycles do not count.

Transitions (taken at timer=0 with en=1):
- NS_G→NS_Y, NS_Y→RED_A, EW_G→EW_Y, EW_Y→RED_B.
- RED_A: to WALK if ped_pend, else to EW_G. Set dir=EW.
- RED_B: to WALK if ped_pend, else to NS_G. Set dir=NS.
- WALK: to NS_G if dir=NS, else to EW_G. dir is a 1-bit register.

Pedestrian latch ped_pend:
- Set on any edge where ped_req=1 and the state is not WALK.
- Cleared on the edge that enters WALK. That clear takes priority over a coincident ped_req.
- ped_req during WALK is ignored.
- ped_req is latched even while en=0.

Illegal state codes (7, or any unreachable encoding):
- Decode to both heads RED, walk=0.
- Next enabled edge goes to RED_B with timer=ALLRED_T-1.

Arithmetic: the timer is CNT_W bits and never wraps, because the load value is always T-1 < 2^CNT_W.

## Timing
- Reset (rst_n low, asynchronous):
  - Outputs: state=RED_B, phase=5, light_ns=light_ew=3'b100, walk=0.
  - Internal: timer=ALLRED_T-1, ped_pend=0, dir=NS.
- After rst_n rises with en=1, the first NS_G appears after ALLRED_T edges.
- Reset asserted mid-phase forces the reset values immediately, regardless of clk.
- Latency from a ped_req edge to walk=1 is at most the remainder of the current road's G+Y+ALLRED sequence.
- Full cycle without pedestrians is 2*(GREEN_T+YELLOW_T+ALLRED_T) enabled cycles; 30 at defaults.
- Each serviced request adds WALK_T cycles, inserted once per clearance interval.

## Test plan
- Reset then en=1, no ped_req (defaults) -> RED_B for 2 cycles; then NS_G for 10, NS_Y for 3, RED_A for 2, EW_G for 10, EW_Y for 3, RED_B for 2. Period is 30 and walk stays 0.
- ped_req pulsed for 1 cycle during NS_G -> after RED_A, WALK for 6 cycles (walk=1, both heads 3'b100), then EW_G. The next RED_B goes straight to NS_G.
- ped_req held high across WALK entry -> exactly one WALK is served. ped_pend is set again only once WALK has exited and ped_req is still high.
- en=0 for 5 cycles in the middle of EW_G (at timer=4) -> outputs frozen. EW_G totals 10 enabled cycles, i.e. 15 wall cycles.
- rst_n asserted asynchronously during WALK -> outputs become 3'b100/3'b100, walk=0, phase=5 without waiting for a clock edge. A pending request is discarded.
- Parameters GREEN_T=1, YELLOW_T=1, ALLRED_T=1, WALK_T=1, CNT_W=1 -> each state lasts 1 cycle, period is 6, and the timer stays at 0.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Two-road intersection controller with programmable phase durations, an
// all-red clearance between roads and a latched pedestrian WALK phase.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   en       - advance enable; low freezes state and timer
//   ped_req  - pedestrian request (level or pulse), latched every edge
//   light_ns - North-South head, one-hot {RED,GREEN,YELLOW}
//   light_ew - East-West head, one-hot {RED,GREEN,YELLOW}
//   walk     - pedestrian walk indication
//   phase    - current state code (0..6)
module traffic_light_ctrl #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_NS_G  = 3'd0,
    ST_NS_Y  = 3'd1,
    ST_RED_A = 3'd2,
    ST_EW_G  = 3'd3,
    ST_EW_Y  = 3'd4,
    ST_RED_B = 3'd5,
    ST_WALK  = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Timer load values: a state lasting T cycles starts at T-1.
  localparam logic [CNT_W-1:0] LD_G = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] LD_Y = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_A = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LD_W = CNT_W'(WALK_T - 1);

  state_t           state_r;
  logic [CNT_W-1:0] timer_r;
  logic             ped_pend_r;
  logic             dir_r;

  state_t           next_state_s;
  logic [CNT_W-1:0] next_timer_s;
  logic             next_pend_s;
  logic             next_dir_s;
  logic             enter_walk_s;

  // Head/walk decode of a state; unknown codes show all-red, no walk.
  function automatic logic [6:0] decode_heads(input state_t s);
    logic [6:0] r;
    case (s)
      ST_NS_G: r = {GREEN,  RED,    1'b0};
      ST_NS_Y: r = {YELLOW, RED,    1'b0};
      ST_EW_G: r = {RED,    GREEN,  1'b0};
      ST_EW_Y: r = {RED,    YELLOW, 1'b0};
      ST_WALK: r = {RED,    RED,    1'b1};
      default: r = {RED,    RED,    1'b0};
    endcase
    return r;
  endfunction

  // Next-state, timer, direction and pedestrian-latch computation.
  always_comb begin
    next_state_s = state_r;
    next_timer_s = timer_r;
    next_dir_s   = dir_r;
    enter_walk_s = 1'b0;
    if (en) begin
      if (state_r == 3'd7) begin
        // Recover from the unused code through a clearance interval.
        next_state_s = ST_RED_B;
        next_timer_s = LD_A;
      end else if (timer_r != '0) begin
        next_timer_s = timer_r - CNT_W'(1);
      end else begin
        case (state_r)
          ST_NS_G: begin
            next_state_s = ST_NS_Y;
            next_timer_s = LD_Y;
          end
          ST_NS_Y: begin
            next_state_s = ST_RED_A;
            next_timer_s = LD_A;
          end
          ST_RED_A: begin
            next_dir_s   = DIR_EW;
            enter_walk_s = ped_pend_r;
            next_state_s = ped_pend_r ? ST_WALK : ST_EW_G;
            next_timer_s = ped_pend_r ? LD_W : LD_G;
          end
          ST_EW_G: begin
            next_state_s = ST_EW_Y;
            next_timer_s = LD_Y;
          end
          ST_EW_Y: begin
            next_state_s = ST_RED_B;
            next_timer_s = LD_A;
          end
          ST_RED_B: begin
            next_dir_s   = DIR_NS;
            enter_walk_s = ped_pend_r;
            next_state_s = ped_pend_r ? ST_WALK : ST_NS_G;
            next_timer_s = ped_pend_r ? LD_W : LD_G;
          end
          ST_WALK: begin
            next_state_s = (dir_r == DIR_NS) ? ST_NS_G : ST_EW_G;
            next_timer_s = LD_G;
          end
          default: begin
            next_state_s = ST_RED_B;
            next_timer_s = LD_A;
          end
        endcase
      end
    end else begin
      next_state_s = state_r;
      next_timer_s = timer_r;
    end

    // Entering WALK clears the latch and wins over a coincident request;
    // the latch ignores en so requests are never lost during a hold.
    if (enter_walk_s) begin
      next_pend_s = 1'b0;
    end else if (ped_req && (state_r != ST_WALK)) begin
      next_pend_s = 1'b1;
    end else begin
      next_pend_s = ped_pend_r;
    end
  end

  // State register; outputs are registered from the next-state decode so
  // they always equal the decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RED_B;
      timer_r    <= LD_A;
      ped_pend_r <= 1'b0;
      dir_r      <= DIR_NS;
      light_ns   <= RED;
      light_ew   <= RED;
      walk       <= 1'b0;
      phase      <= 3'd5;
    end else begin
      state_r    <= next_state_s;
      timer_r    <= next_timer_s;
      ped_pend_r <= next_pend_s;
      dir_r      <= next_dir_s;
      {light_ns, light_ew, walk} <= decode_heads(next_state_s);
      phase      <= next_state_s;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns1, ew1, ph1, ns2, ew2, ph2;
  logic       wk1, wk2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .light_ns(ns1), .light_ew(ew1), .walk(wk1), .phase(ph1)
  );

  traffic_light_ctrl #(
    .CNT_W(1), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1), .WALK_T(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .light_ns(ns2), .light_ew(ew2), .walk(wk2), .phase(ph2)
  );

  // Reference model: phase name, enabled cycles spent in it, latch, direction.
  typedef struct {
    int ph;
    int el;
    bit pend;
    bit dir_ns;
  } model_t;

  typedef struct {
    bit en;
    bit ped;
    int exp_phase;
  } vec_t;

  model_t m1, m2;

  function automatic model_t mreset();
    model_t m;
    m.ph = 5; m.el = 0; m.pend = 1'b0; m.dir_ns = 1'b1;
    return m;
  endfunction

  function automatic model_t mstep(model_t m, bit e, bit p,
                                   int g, int y, int a, int w);
    model_t n = m;
    int d;
    bit last, ew;
    case (m.ph)
      0, 3:    d = g;
      1, 4:    d = y;
      2, 5:    d = a;
      default: d = w;
    endcase
    last = e && (m.el + 1 >= d);
    ew = last && (m.ph == 2 || m.ph == 5) && m.pend;
    if (e) begin
      if (last) begin
        n.el = 0;
        case (m.ph)
          0: n.ph = 1;
          1: n.ph = 2;
          2: begin n.ph = m.pend ? 6 : 3; n.dir_ns = 1'b0; end
          3: n.ph = 4;
          4: n.ph = 5;
          5: begin n.ph = m.pend ? 6 : 0; n.dir_ns = 1'b1; end
          default: n.ph = m.dir_ns ? 0 : 3;
        endcase
      end else begin
        n.el = m.el + 1;
      end
    end
    if (ew) n.pend = 1'b0;
    else if (p && m.ph != 6) n.pend = 1'b1;
    return n;
  endfunction

  function automatic int exp_ns(int ph);
    case (ph)
      0: return 2;
      1: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_ew(int ph);
    case (ph)
      3: return 2;
      4: return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_phase(input string tag, input int p1, input int p2);
    chk({tag, ".phase1"}, int'(ph1), p1);
    chk({tag, ".ns1"},    int'(ns1), exp_ns(p1));
    chk({tag, ".ew1"},    int'(ew1), exp_ew(p1));
    chk({tag, ".walk1"},  int'(wk1), (p1 == 6) ? 1 : 0);
    chk({tag, ".phase2"}, int'(ph2), p2);
    chk({tag, ".ns2"},    int'(ns2), exp_ns(p2));
    chk({tag, ".ew2"},    int'(ew2), exp_ew(p2));
    chk({tag, ".walk2"},  int'(wk2), (p2 == 6) ? 1 : 0);
  endtask

  // One clock: models advance with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    m1 = mstep(m1, en, ped_req, 10, 3, 2, 6);
    m2 = mstep(m2, en, ped_req, 1, 1, 1, 1);
    #1;
    chk_phase("model", m1.ph, m2.ph);
  endtask

  task automatic wait_phase1(input string name, input int ph, input int bound);
    int n = 0;
    while (int'(ph1) != ph && n < bound) begin
      step();
      n++;
    end
    chk({name, ".reached"}, int'(ph1), ph);
  endtask

  vec_t vecs[32];
  int   run_ph[8]  = '{5, 0, 1, 2, 3, 4, 5, 0};
  int   run_len[8] = '{1, 10, 3, 2, 10, 3, 2, 1};

  initial begin
    int k, n;

    // Expected sequence after reset: the RED_B remainder, then a full period.
    k = 0;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < run_len[r]; j++) begin
        vecs[k].en = 1'b1;
        vecs[k].ped = 1'b0;
        vecs[k].exp_phase = run_ph[r];
        k++;
      end
    end

    m1 = mreset();
    m2 = mreset();
    #12;
    chk_phase("reset", 5, 5);
    rst_n = 1'b1;

    // Default period from reset, table driven.
    for (int i = 0; i < 32; i++) begin
      en = vecs[i].en;
      ped_req = vecs[i].ped;
      step();
      chk($sformatf("vec%0d.phase", i), int'(ph1), vecs[i].exp_phase);
      chk($sformatf("vec%0d.walk", i), int'(wk1), 0);
    end

    // One-cycle pedestrian pulse during NS_G.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase1("pulse_walk", 6, 40);
    n = 0;
    while (wk1 == 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("pulse_walk_len", n, 6);
    chk("pulse_after_walk", int'(ph1), 3);
    wait_phase1("pulse_red_b", 5, 40);
    n = 0;
    while (int'(ph1) == 5 && n < 10) begin
      step();
      n++;
    end
    chk("pulse_red_b_to_ns_g", int'(ph1), 0);

    // Request held across WALK entry: one WALK, latch re-set after exit.
    ped_req = 1'b1;
    wait_phase1("held_walk", 6, 40);
    n = 0;
    while (wk1 == 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("held_walk_len", n, 6);
    chk("held_after_walk", int'(ph1), 3);
    step();
    ped_req = 1'b0;
    wait_phase1("held_second_walk", 6, 40);
    wait_phase1("held_back_ns_g", 0, 20);

    // Freeze for 5 cycles inside EW_G at timer=4.
    wait_phase1("frz_ew_g", 3, 60);
    n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      n++;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_hold", int'(ph1), 3);
      n++;
    end
    en = 1'b1;
    k = 0;
    while (int'(ph1) == 3 && k < 30) begin
      step();
      if (int'(ph1) == 3) n++;
      k++;
    end
    chk("frz_ew_g_wall", n, 15);
    chk("frz_next", int'(ph1), 4);

    // Asynchronous reset during WALK.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase1("rst_walk", 6, 60);
    #2;
    rst_n = 1'b0;
    #1;
    m1 = mreset();
    m2 = mreset();
    chk_phase("async_rst", 5, 5);
    @(posedge clk);
    #1;
    chk_phase("rst_held", 5, 5);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      step();
      chk("rst_no_walk", int'(wk1), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      ped_req = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
